// File: rtl/tlp_mrd_axi_ar.sv
// Memory Read TLP to AXI4 read-address bridge.
// Decodes MRd headers and emits one completion context per request.
// Then issues INCR AR bursts covering the requested bytes, split at 4 KB pages.
// Malformed TLPs and non-MRd TLPs are drained, and each one is flagged on err_drop.
module tlp_mrd_axi_ar #(
    parameter int unsigned DOUBLE_WORD    = 32,
    parameter int unsigned HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int unsigned TLP_DATA_WIDTH = 8 * DOUBLE_WORD,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [TLP_DATA_WIDTH-1:0] r_in_data,
    input  logic [HEADER_SIZE-1:0]    r_in_hdr,
    input  logic                      r_in_sop,
    input  logic                      r_in_eop,
    input  logic                      r_in_valid,
    output logic                      r_in_ready,
    output logic                      ctx_valid,
    input  logic                      ctx_ready,
    output logic [7:0]                ctx_tag,
    output logic [15:0]               ctx_req_id,
    output logic [2:0]                ctx_tc,
    output logic [1:0]                ctx_attr,
    output logic [10:0]               ctx_len_dw,
    output logic [6:0]                ctx_lower_addr,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic                      err_drop
);

    localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG_B = $clog2(BYTES);
    localparam int unsigned CW    = 13;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CTX   = 2'd2;
    localparam logic [1:0] S_AR    = 2'd3;

    // Bytes that can be read from address a without crossing a 4 KB page.
    function automatic logic [CW-1:0] chunk_of(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [CW-1:0] rem);
        logic [CW-1:0] page_left;
        page_left = CW'(13'd4096 - {1'b0, a[11:0]});
        return (rem < page_left) ? rem : page_left;
    endfunction

    // AXI arlen for a chunk starting at unaligned address a.
    function automatic logic [7:0] arlen_of(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [CW-1:0] chunk);
        logic [CW-1:0] span;
        span = CW'(a[LOG_B-1:0]) + chunk + CW'(BYTES - 1);
        return 8'((span >> LOG_B) - CW'(1));
    endfunction

    logic [1:0]            state, state_d;
    logic                  legal_q, legal_d;
    logic                  idle_q, drain_q;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d;
    logic [CW-1:0]         cur_rem, cur_rem_d;
    logic [7:0]            tag_d;
    logic [15:0]           req_id_d;
    logic [2:0]            tc_d;
    logic [1:0]            attr_d;
    logic [10:0]           len_dw_d;
    logic [6:0]            lower_addr_d;
    logic [ADDR_WIDTH-1:0] araddr_d;
    logic [7:0]            arlen_d;
    logic [ID_WIDTH-1:0]   arid_d;
    logic                  err_d;

    logic                  hs;
    logic [2:0]            hdr_fmt;
    logic [4:0]            hdr_type;
    logic                  hdr_ok;
    logic [10:0]           hdr_len_dw;
    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [CW-1:0]         cur_chunk;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [CW-1:0]         nxt_rem;
    logic                  unused_bits;

    assign hs       = r_in_valid & r_in_ready;
    assign hdr_fmt  = r_in_hdr[31:29];
    assign hdr_type = r_in_hdr[28:24];
    assign hdr_ok   = (hdr_type == 5'b00000) && (hdr_fmt[2:1] == 2'b00);
    assign hdr_len_dw = (r_in_hdr[9:0] == 10'd0) ? 11'd1024 : {1'b0, r_in_hdr[9:0]};
    assign hdr_addr = hdr_fmt[0] ? ADDR_WIDTH'({r_in_hdr[95:64], r_in_hdr[127:98], 2'b00})
                                 : ADDR_WIDTH'({32'd0, r_in_hdr[95:66], 2'b00});

    assign cur_chunk = chunk_of(cur_addr, cur_rem);
    assign nxt_addr  = cur_addr + ADDR_WIDTH'(cur_chunk);
    assign nxt_rem   = cur_rem - cur_chunk;

    // Stream accept: always in DRAIN, gated by enable in IDLE, low during reset.
    assign r_in_ready    = drain_q | (idle_q & enable);
    assign m_axi_arsize  = 3'(LOG_B);
    assign m_axi_arburst = 2'b01;

    // Header bits the bridge never looks at.
    assign unused_bits = ^{r_in_data, r_in_hdr[23], r_in_hdr[19:14], r_in_hdr[11:10],
                           r_in_hdr[39:32], r_in_hdr[97:96]};

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        legal_d      = legal_q;
        cur_addr_d   = cur_addr;
        cur_rem_d    = cur_rem;
        tag_d        = ctx_tag;
        req_id_d     = ctx_req_id;
        tc_d         = ctx_tc;
        attr_d       = ctx_attr;
        len_dw_d     = ctx_len_dw;
        lower_addr_d = ctx_lower_addr;
        araddr_d     = m_axi_araddr;
        arlen_d      = m_axi_arlen;
        arid_d       = m_axi_arid;
        err_d        = 1'b0;

        case (state)
            S_IDLE: begin
                if (hs) begin
                    if (!r_in_sop) begin
                        err_d = 1'b1;
                    end else if (hdr_ok) begin
                        tag_d        = r_in_hdr[47:40];
                        req_id_d     = r_in_hdr[63:48];
                        tc_d         = r_in_hdr[22:20];
                        attr_d       = r_in_hdr[13:12];
                        len_dw_d     = hdr_len_dw;
                        lower_addr_d = hdr_addr[6:0];
                        cur_addr_d   = hdr_addr;
                        cur_rem_d    = CW'({hdr_len_dw, 2'b00});
                        legal_d      = 1'b1;
                        state_d      = r_in_eop ? S_CTX : S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        legal_d = 1'b0;
                        state_d = r_in_eop ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (hs && r_in_eop) begin
                    state_d = legal_q ? S_CTX : S_IDLE;
                end
            end
            S_CTX: begin
                if (ctx_ready) begin
                    state_d  = S_AR;
                    araddr_d = cur_addr;
                    arlen_d  = arlen_of(cur_addr, cur_chunk);
                    arid_d   = ctx_tag[ID_WIDTH-1:0];
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    cur_addr_d = nxt_addr;
                    cur_rem_d  = nxt_rem;
                    if (nxt_rem == CW'(0)) begin
                        state_d = S_IDLE;
                    end else begin
                        araddr_d = nxt_addr;
                        arlen_d  = arlen_of(nxt_addr, chunk_of(nxt_addr, nxt_rem));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            legal_q        <= 1'b0;
            idle_q         <= 1'b0;
            drain_q        <= 1'b0;
            cur_addr       <= '0;
            cur_rem        <= '0;
            ctx_valid      <= 1'b0;
            ctx_tag        <= '0;
            ctx_req_id     <= '0;
            ctx_tc         <= '0;
            ctx_attr       <= '0;
            ctx_len_dw     <= '0;
            ctx_lower_addr <= '0;
            m_axi_araddr   <= '0;
            m_axi_arlen    <= '0;
            m_axi_arid     <= '0;
            m_axi_arvalid  <= 1'b0;
            err_drop       <= 1'b0;
        end else begin
            state          <= state_d;
            legal_q        <= legal_d;
            idle_q         <= (state_d == S_IDLE);
            drain_q        <= (state_d == S_DRAIN);
            cur_addr       <= cur_addr_d;
            cur_rem        <= cur_rem_d;
            ctx_valid      <= (state_d == S_CTX);
            ctx_tag        <= tag_d;
            ctx_req_id     <= req_id_d;
            ctx_tc         <= tc_d;
            ctx_attr       <= attr_d;
            ctx_len_dw     <= len_dw_d;
            ctx_lower_addr <= lower_addr_d;
            m_axi_araddr   <= araddr_d;
            m_axi_arlen    <= arlen_d;
            m_axi_arid     <= arid_d;
            m_axi_arvalid  <= (state_d == S_AR);
            err_drop       <= err_d;
        end
    end

endmodule
